// File: rtl/issue_queue_pkg.sv
// Shared opcode constants, dispatch classes and decode helpers for the issue queue.
// Defining IQ_CDB_BYPASS_EN (see iq_operand_resolve) adds the CDB snoop step.
package issue_queue_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } iq_class_e;

    localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_W-1:0] OP_LB    = 6'd11;
    localparam logic [OP_W-1:0] OP_LH    = 6'd12;
    localparam logic [OP_W-1:0] OP_LW    = 6'd13;
    localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
    localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
    localparam logic [OP_W-1:0] OP_SB    = 6'd16;
    localparam logic [OP_W-1:0] OP_SH    = 6'd17;
    localparam logic [OP_W-1:0] OP_SW    = 6'd18;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
    localparam logic [OP_W-1:0] OP_OR    = 6'd36;
    localparam logic [OP_W-1:0] OP_AND   = 6'd37;

    function automatic iq_class_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:          return CLS_LOAD;
            OP_SB, OP_SH, OP_SW:                           return CLS_STORE;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return CLS_BRANCH;
            default:                                       return CLS_ALU;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [OP_W-1:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL: return 1'b0;
            default:                  return 1'b1;
        endcase
    endfunction

    // rs2 is read only by branches, stores and register-register ALU ops
    function automatic logic uses_rs2(input logic [OP_W-1:0] op);
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
            OP_SB, OP_SH, OP_SW,
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/iq_operand_resolve.sv
// Resolves one head source operand against regfile, ROB and (with IQ_CDB_BYPASS_EN) the CDB.
// Without IQ_CDB_BYPASS_EN a same-cycle CDB hit raises stall so the RS cannot miss the broadcast.
module iq_operand_resolve
    import issue_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
) (
    input  logic              used,
    input  logic [REG_W-1:0]  rs,
    input  logic              busy,
    input  logic [DATA_W-1:0] rf_val,
    input  logic              rob_rdy,
    input  logic [DATA_W-1:0] rob_val,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_robpos,
    input  logic [DATA_W-1:0] cdb_val,
    output logic [DATA_W-1:0] v,
    output logic              q,
    output logic [ROB_W-1:0]  tag,
    output logic              stall
);

    logic [ROB_W-1:0] rf_tag;
    logic             cdb_hit;

    assign rf_tag  = rf_val[ROB_W-1:0];
    assign cdb_hit = cdb_valid && (cdb_robpos == rf_tag);

`ifndef IQ_CDB_BYPASS_EN
    logic unused_cdb_val;
    assign unused_cdb_val = ^cdb_val;
`endif

    always_comb begin
        v     = '0;
        q     = 1'b0;
        tag   = '0;
        stall = 1'b0;
        if (!used || rs == '0) begin
            v = '0;
        end else if (!busy) begin
            v = rf_val;
        end else if (rob_rdy) begin
            v = rob_val;
`ifdef IQ_CDB_BYPASS_EN
        end else if (cdb_hit) begin
            v = cdb_val;
`endif
        end else begin
            q   = 1'b1;
            tag = rf_tag;
`ifndef IQ_CDB_BYPASS_EN
            stall = cdb_hit;
`endif
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order IQ_DEPTH-entry issue queue between decode and RS/LSB/ROB, with mispredict flush.
// Optional IQ_CDB_BYPASS_EN selects CDB snooping instead of a one-cycle bypass stall.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_DEPTH = 4,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 4,
    parameter int RS_W     = 4,
    parameter int LSB_W    = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              dec_valid,
    input  logic [OP_W-1:0]   dec_op,
    input  logic [REG_W-1:0]  dec_rd,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic [DATA_W-1:0] dec_imm,
    input  logic [DATA_W-1:0] dec_pc,
    input  logic [DATA_W-1:0] dec_pred_pc,
    output logic              dec_ready,
    output logic [REG_W-1:0]  rf_rs1_idx,
    output logic [REG_W-1:0]  rf_rs2_idx,
    input  logic              rf_rs1_busy,
    input  logic              rf_rs2_busy,
    input  logic [DATA_W-1:0] rf_rs1_val,
    input  logic [DATA_W-1:0] rf_rs2_val,
    output logic [ROB_W-1:0]  rob_q1_pos,
    output logic [ROB_W-1:0]  rob_q2_pos,
    input  logic              rob_q1_rdy,
    input  logic              rob_q2_rdy,
    input  logic [DATA_W-1:0] rob_q1_val,
    input  logic [DATA_W-1:0] rob_q2_val,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_robpos,
    input  logic [DATA_W-1:0] cdb_val,
    input  logic              rob_avail,
    input  logic [ROB_W-1:0]  rob_avail_pos,
    input  logic              rs_avail,
    input  logic [RS_W-1:0]   rs_avail_pos,
    input  logic              lsb_avail,
    input  logic [LSB_W-1:0]  lsb_avail_pos,
    output logic              rob_push,
    output logic              rs_push,
    output logic              lsb_push,
    output logic              rf_lock,
    output logic [REG_W-1:0]  rf_lock_rd,
    output logic [ROB_W-1:0]  rf_lock_robpos,
    output logic [OP_W-1:0]   iss_op,
    output logic [REG_W-1:0]  iss_rd,
    output logic [DATA_W-1:0] iss_imm,
    output logic [DATA_W-1:0] iss_pc,
    output logic [DATA_W-1:0] iss_pred_pc,
    output logic [ROB_W-1:0]  iss_robpos,
    output logic [RS_W-1:0]   iss_rspos,
    output logic [LSB_W-1:0]  iss_lsbpos,
    output logic [DATA_W-1:0] iss_vj,
    output logic              iss_qj,
    output logic [ROB_W-1:0]  iss_jtag,
    output logic [DATA_W-1:0] iss_vk,
    output logic              iss_qk,
    output logic [ROB_W-1:0]  iss_ktag
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pred_pc;
    } iq_entry_t;

    iq_entry_t        mem [IQ_DEPTH];
    iq_entry_t        head_e;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    iq_class_e        head_cls;
    logic             not_empty, is_lsb, target_avail, bypass_stall;
    logic             push, fire;

    logic [DATA_W-1:0] vj, vk;
    logic              qj, qk, stall_j, stall_k;
    logic [ROB_W-1:0]  jtag, ktag;

    assign head_e     = mem[head];
    assign head_cls   = op_class(head_e.op);
    assign not_empty  = (count != '0);
    assign is_lsb     = (head_cls == CLS_LOAD) || (head_cls == CLS_STORE);

    assign rf_rs1_idx = head_e.rs1;
    assign rf_rs2_idx = head_e.rs2;
    assign rob_q1_pos = rf_rs1_val[ROB_W-1:0];
    assign rob_q2_pos = rf_rs2_val[ROB_W-1:0];

    iq_operand_resolve #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_res_j (
        .used       (uses_rs1(head_e.op)),
        .rs         (head_e.rs1),
        .busy       (rf_rs1_busy),
        .rf_val     (rf_rs1_val),
        .rob_rdy    (rob_q1_rdy),
        .rob_val    (rob_q1_val),
        .cdb_valid  (cdb_valid),
        .cdb_robpos (cdb_robpos),
        .cdb_val    (cdb_val),
        .v          (vj),
        .q          (qj),
        .tag        (jtag),
        .stall      (stall_j)
    );

    iq_operand_resolve #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_res_k (
        .used       (uses_rs2(head_e.op)),
        .rs         (head_e.rs2),
        .busy       (rf_rs2_busy),
        .rf_val     (rf_rs2_val),
        .rob_rdy    (rob_q2_rdy),
        .rob_val    (rob_q2_val),
        .cdb_valid  (cdb_valid),
        .cdb_robpos (cdb_robpos),
        .cdb_val    (cdb_val),
        .v          (vk),
        .q          (qk),
        .tag        (ktag),
        .stall      (stall_k)
    );

    // dec_ready looks only at registered occupancy, so a full queue never accepts on a same-cycle pop
    assign dec_ready    = (count < CNT_W'(IQ_DEPTH));
    assign bypass_stall = not_empty && (stall_j || stall_k);
    assign target_avail = is_lsb ? lsb_avail : rs_avail;
    assign push         = dec_valid && dec_ready && rdy_in && !flush_in;
    assign fire         = rdy_in && !flush_in && not_empty && rob_avail && target_avail && !bypass_stall;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (fire) head <= head + 1'b1;
                count <= count + CNT_W'(push) - CNT_W'(fire);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[tail] <= '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
                           imm: dec_imm, pc: dec_pc, pred_pc: dec_pred_pc};
        end
    end

    // Payload is held at zero unless this cycle dispatches
    always_comb begin
        rob_push       = 1'b0;
        rs_push        = 1'b0;
        lsb_push       = 1'b0;
        rf_lock        = 1'b0;
        rf_lock_rd     = '0;
        rf_lock_robpos = '0;
        iss_op         = '0;
        iss_rd         = '0;
        iss_imm        = '0;
        iss_pc         = '0;
        iss_pred_pc    = '0;
        iss_robpos     = '0;
        iss_rspos      = '0;
        iss_lsbpos     = '0;
        iss_vj         = '0;
        iss_qj         = 1'b0;
        iss_jtag       = '0;
        iss_vk         = '0;
        iss_qk         = 1'b0;
        iss_ktag       = '0;
        if (fire) begin
            rob_push       = 1'b1;
            rs_push        = !is_lsb;
            lsb_push       = is_lsb;
            rf_lock        = (head_cls != CLS_STORE) && (head_cls != CLS_BRANCH) && (head_e.rd != '0);
            rf_lock_rd     = head_e.rd;
            rf_lock_robpos = rob_avail_pos;
            iss_op         = head_e.op;
            iss_rd         = head_e.rd;
            iss_imm        = head_e.imm;
            iss_pc         = head_e.pc;
            iss_pred_pc    = head_e.pred_pc;
            iss_robpos     = rob_avail_pos;
            iss_rspos      = rs_avail_pos;
            iss_lsbpos     = lsb_avail_pos;
            iss_vj         = vj;
            iss_qj         = qj;
            iss_jtag       = jtag;
            iss_vk         = vk;
            iss_qk         = qk;
            iss_ktag       = ktag;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue; expectations follow IQ_CDB_BYPASS_EN when it is defined.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int RS_W   = 4;
    localparam int LSB_W  = 4;

    logic              clk_in = 1'b0;
    logic              rst_in, rdy_in, flush_in, dec_valid;
    logic [OP_W-1:0]   dec_op;
    logic [REG_W-1:0]  dec_rd, dec_rs1, dec_rs2;
    logic [DATA_W-1:0] dec_imm, dec_pc, dec_pred_pc;
    logic              dec_ready;
    logic [REG_W-1:0]  rf_rs1_idx, rf_rs2_idx;
    logic              rf_rs1_busy, rf_rs2_busy;
    logic [DATA_W-1:0] rf_rs1_val, rf_rs2_val;
    logic [ROB_W-1:0]  rob_q1_pos, rob_q2_pos;
    logic              rob_q1_rdy, rob_q2_rdy;
    logic [DATA_W-1:0] rob_q1_val, rob_q2_val;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_robpos;
    logic [DATA_W-1:0] cdb_val;
    logic              rob_avail, rs_avail, lsb_avail;
    logic [ROB_W-1:0]  rob_avail_pos;
    logic [RS_W-1:0]   rs_avail_pos;
    logic [LSB_W-1:0]  lsb_avail_pos;
    logic              rob_push, rs_push, lsb_push, rf_lock;
    logic [REG_W-1:0]  rf_lock_rd, iss_rd;
    logic [ROB_W-1:0]  rf_lock_robpos, iss_robpos, iss_jtag, iss_ktag;
    logic [OP_W-1:0]   iss_op;
    logic [DATA_W-1:0] iss_imm, iss_pc, iss_pred_pc, iss_vj, iss_vk;
    logic [RS_W-1:0]   iss_rspos;
    logic [LSB_W-1:0]  iss_lsbpos;
    logic              iss_qj, iss_qk;

    int vectors    = 0;
    int miscompares = 0;

    issue_queue #(.IQ_DEPTH(4), .DATA_W(DATA_W), .ROB_W(ROB_W), .RS_W(RS_W), .LSB_W(LSB_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .dec_valid(dec_valid), .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_pred_pc(dec_pred_pc), .dec_ready(dec_ready),
        .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
        .rf_rs1_busy(rf_rs1_busy), .rf_rs2_busy(rf_rs2_busy),
        .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
        .rob_q1_pos(rob_q1_pos), .rob_q2_pos(rob_q2_pos),
        .rob_q1_rdy(rob_q1_rdy), .rob_q2_rdy(rob_q2_rdy),
        .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
        .cdb_valid(cdb_valid), .cdb_robpos(cdb_robpos), .cdb_val(cdb_val),
        .rob_avail(rob_avail), .rob_avail_pos(rob_avail_pos),
        .rs_avail(rs_avail), .rs_avail_pos(rs_avail_pos),
        .lsb_avail(lsb_avail), .lsb_avail_pos(lsb_avail_pos),
        .rob_push(rob_push), .rs_push(rs_push), .lsb_push(lsb_push),
        .rf_lock(rf_lock), .rf_lock_rd(rf_lock_rd), .rf_lock_robpos(rf_lock_robpos),
        .iss_op(iss_op), .iss_rd(iss_rd), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_pred_pc(iss_pred_pc),
        .iss_robpos(iss_robpos), .iss_rspos(iss_rspos), .iss_lsbpos(iss_lsbpos),
        .iss_vj(iss_vj), .iss_qj(iss_qj), .iss_jtag(iss_jtag),
        .iss_vk(iss_vk), .iss_qk(iss_qk), .iss_ktag(iss_ktag)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [OP_W-1:0] op, input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                 input logic [DATA_W-1:0] imm);
        dec_valid   = valid;
        dec_op      = op;
        dec_rd      = rd;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_imm     = imm;
        dec_pc      = 32'h1000 + imm;
        dec_pred_pc = 32'h2000 + imm;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        rf_rs1_busy = 1'b0; rf_rs2_busy = 1'b0;
        rf_rs1_val = 32'h111; rf_rs2_val = 32'h222;
        rob_q1_rdy = 1'b0; rob_q2_rdy = 1'b0; rob_q1_val = 32'h0; rob_q2_val = 32'h0;
        cdb_valid = 1'b0; cdb_robpos = '0; cdb_val = 32'h0;
        rob_avail = 1'b0; rob_avail_pos = '0;
        rs_avail = 1'b0; rs_avail_pos = '0;
        lsb_avail = 1'b0; lsb_avail_pos = '0;

        // reset state
        @(negedge clk_in); #1;
        checkOutput("rst_dec_ready", 64'(dec_ready), 64'd1);
        checkOutput("rst_rob_push", 64'(rob_push), 64'd0);
        checkOutput("rst_iss_op", 64'(iss_op), 64'd0);

        // ADDI x1,x0,5 into empty queue: dispatch one cycle later
        @(negedge clk_in);
        rst_in = 1'b1; rob_avail = 1'b1; rs_avail = 1'b1; rob_avail_pos = 4'd2; rs_avail_pos = 4'd6;
        applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        #1 checkOutput("addi_push_cycle", 64'(rob_push), 64'd0);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        checkOutput("addi_rs_push", 64'(rs_push), 64'd1);
        checkOutput("addi_rob_push", 64'(rob_push), 64'd1);
        checkOutput("addi_lsb_push", 64'(lsb_push), 64'd0);
        checkOutput("addi_rf_lock", 64'(rf_lock), 64'd1);
        checkOutput("addi_lock_rd", 64'(rf_lock_rd), 64'd1);
        checkOutput("addi_lock_robpos", 64'(rf_lock_robpos), 64'd2);
        checkOutput("addi_robpos", 64'(iss_robpos), 64'd2);
        checkOutput("addi_rspos", 64'(iss_rspos), 64'd6);
        checkOutput("addi_vj", 64'(iss_vj), 64'd0);
        checkOutput("addi_qj", 64'(iss_qj), 64'd0);
        checkOutput("addi_imm", 64'(iss_imm), 64'd5);
        checkOutput("addi_pc", 64'(iss_pc), 64'h1005);
        @(negedge clk_in); #1;
        checkOutput("addi_drained", 64'(rob_push), 64'd0);

        // fill past depth with ROB blocked, then drain with a push during a pop
        rob_avail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            applyStimulus(1'b1, OP_ADDI, 5'(i + 1), 5'd1, 5'd0, 32'(10 + i));
            #1 checkOutput($sformatf("fill_ready_%0d", i), 64'(dec_ready), (i < 4) ? 64'd1 : 64'd0);
        end
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        rob_avail = 1'b1;
        #1;
        checkOutput("drain0_fire", 64'(rob_push), 64'd1);
        checkOutput("drain0_imm", 64'(iss_imm), 64'd10);
        checkOutput("drain0_ready", 64'(dec_ready), 64'd0);
        checkOutput("drain0_vj", 64'(iss_vj), 64'h111);
        @(negedge clk_in);
        applyStimulus(1'b1, OP_ADDI, 5'd9, 5'd0, 5'd0, 32'd20);
        #1;
        checkOutput("drain1_ready", 64'(dec_ready), 64'd1);
        checkOutput("drain1_imm", 64'(iss_imm), 64'd11);
        checkOutput("drain1_rd", 64'(iss_rd), 64'd2);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        #1 checkOutput("drain2_imm", 64'(iss_imm), 64'd12);
        @(negedge clk_in); #1 checkOutput("drain3_imm", 64'(iss_imm), 64'd13);
        @(negedge clk_in); #1 checkOutput("drain4_imm", 64'(iss_imm), 64'd20);
        @(negedge clk_in); #1 checkOutput("drain_empty", 64'(rob_push), 64'd0);

        // SW waits for LSB space
        @(negedge clk_in);
        lsb_avail = 1'b0;
        applyStimulus(1'b1, OP_SW, 5'd0, 5'd2, 5'd3, 32'd8);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        checkOutput("sw_blocked_lsb", 64'(lsb_push), 64'd0);
        checkOutput("sw_blocked_rob", 64'(rob_push), 64'd0);
        checkOutput("sw_rs1_idx", 64'(rf_rs1_idx), 64'd2);
        @(negedge clk_in);
        lsb_avail = 1'b1; lsb_avail_pos = 4'd5;
        #1;
        checkOutput("sw_lsb_push", 64'(lsb_push), 64'd1);
        checkOutput("sw_rs_push", 64'(rs_push), 64'd0);
        checkOutput("sw_rf_lock", 64'(rf_lock), 64'd0);
        checkOutput("sw_vk", 64'(iss_vk), 64'h222);
        checkOutput("sw_lsbpos", 64'(iss_lsbpos), 64'd5);
        @(negedge clk_in); #1 checkOutput("sw_drained", 64'(lsb_push), 64'd0);

        // busy source with no result anywhere dispatches with a tag
        @(negedge clk_in);
        applyStimulus(1'b1, OP_ADD, 5'd4, 5'd5, 5'd6, 32'd0);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        rf_rs1_busy = 1'b1; rf_rs1_val = 32'd7;
        #1;
        checkOutput("tag_rs_push", 64'(rs_push), 64'd1);
        checkOutput("tag_qj", 64'(iss_qj), 64'd1);
        checkOutput("tag_jtag", 64'(iss_jtag), 64'd7);
        checkOutput("tag_vj", 64'(iss_vj), 64'd0);
        checkOutput("tag_q1_pos", 64'(rob_q1_pos), 64'd7);
        checkOutput("tag_vk", 64'(iss_vk), 64'h222);

        // busy source whose tag is on the CDB this cycle
        @(negedge clk_in);
        rf_rs1_busy = 1'b0; rf_rs1_val = 32'h111;
        applyStimulus(1'b1, OP_ADD, 5'd4, 5'd5, 5'd6, 32'd0);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        rf_rs1_busy = 1'b1; rf_rs1_val = 32'd3; rob_q1_rdy = 1'b0;
        cdb_valid = 1'b1; cdb_robpos = 4'd3; cdb_val = 32'h1234;
        #1;
`ifdef IQ_CDB_BYPASS_EN
        checkOutput("cdb_rs_push", 64'(rs_push), 64'd1);
        checkOutput("cdb_vj", 64'(iss_vj), 64'h1234);
        checkOutput("cdb_qj", 64'(iss_qj), 64'd0);
`else
        checkOutput("cdb_stall", 64'(rob_push), 64'd0);
        @(negedge clk_in);
        cdb_valid = 1'b0; rob_q1_rdy = 1'b1; rob_q1_val = 32'h1234;
        #1;
        checkOutput("cdb_rs_push", 64'(rs_push), 64'd1);
        checkOutput("cdb_vj", 64'(iss_vj), 64'h1234);
        checkOutput("cdb_qj", 64'(iss_qj), 64'd0);
`endif
        @(negedge clk_in);
        cdb_valid = 1'b0; rob_q1_rdy = 1'b0; rf_rs1_busy = 1'b0; rf_rs1_val = 32'h111;
        #1 checkOutput("cdb_drained", 64'(rob_push), 64'd0);

        // flush with two queued entries and a same-cycle offer
        rs_avail = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(40 + i));
        end
        @(negedge clk_in);
        applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd42);
        flush_in = 1'b1; rs_avail = 1'b1;
        #1 checkOutput("flush_no_fire", 64'(rob_push), 64'd0);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        flush_in = 1'b0;
        #1;
        checkOutput("flush_empty", 64'(rob_push), 64'd0);
        checkOutput("flush_ready", 64'(dec_ready), 64'd1);

        // rdy_in low freezes dispatch
        @(negedge clk_in);
        applyStimulus(1'b1, OP_ADDI, 5'd3, 5'd0, 5'd0, 32'h33);
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        rdy_in = 1'b0;
        #1;
        checkOutput("rdy_low_rob", 64'(rob_push), 64'd0);
        checkOutput("rdy_low_lock", 64'(rf_lock), 64'd0);
        @(negedge clk_in);
        rdy_in = 1'b1;
        #1;
        checkOutput("rdy_high_fire", 64'(rob_push), 64'd1);
        checkOutput("rdy_high_imm", 64'(iss_imm), 64'h33);

        // reset mid-stream with three entries queued
        rob_avail = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            applyStimulus(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(50 + i));
        end
        @(negedge clk_in);
        applyStimulus(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd0);
        rst_in = 1'b0;
        #1 checkOutput("midrst_no_strobe", 64'(rob_push), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1; rob_avail = 1'b1;
        #1;
        checkOutput("midrst_empty", 64'(rob_push), 64'd0);
        checkOutput("midrst_ready", 64'(dec_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
